stack_sequencer: RTL

STACK_SEQUENCER -- requirements
Module: stack_sequencer

---
 rtl/stack_seq_pkg.sv | 35 +++
 rtl/stack_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/stack_seq_pkg.sv
// Shared types for the stack sequencer: FSM states, operation kinds and the
// memory/stack-pointer strobe bundle with its all-inactive value.
package stack_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PUSH_DEC,
        S_PUSH_ADDR,
        S_PUSH_WR,
        S_POP_ADDR,
        S_POP_RD,
        S_POP_INC,
        S_FAULT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_FAULT,
        OP_PUSH,
        OP_POP
    } op_t;

    // All strobes are active-low.
    typedef struct packed {
        logic sp_cdownn;
        logic sp_cupn;
        logic sp_outn;
        logic mar_loadn;
        logic mem_wen;
        logic mem_oen;
    } strobes_t;

    localparam strobes_t STROBES_OFF = strobes_t'(6'b111111);

endpackage

// File: rtl/stack_sequencer.sv
// Sequences push/pop transfers between an external stack pointer, address
// register and byte memory, tracking occupancy and flagging over/underflow.
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | waiting for push/pop request
// PUSH_DEC  | decrement stack pointer
// PUSH_ADDR | drive SP onto address bus, load MAR
// PUSH_WR   | write latched byte to memory
// POP_ADDR  | drive SP onto address bus, load MAR
// POP_RD    | memory output enable, capture read byte
// POP_INC   | increment stack pointer
// FAULT     | rejected request (overflow/underflow), no strobes
// DONE      | one-cycle completion, occupancy update
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int MAX_DEPTH = 256,
    localparam int DW = $clog2(MAX_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    dout,
    output logic [7:0]    mem_wdata,
    output logic          sp_cdownn,
    output logic          sp_cupn,
    output logic          sp_outn,
    output logic          mar_loadn,
    output logic          mem_wen,
    output logic          mem_oen,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] depth
);

    state_t   state, state_nxt;
    strobes_t strb;
    op_t      op;
    logic     full, empty;

    assign full  = (depth == DW'(MAX_DEPTH));
    assign empty = (depth == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        strb      = STROBES_OFF;
        case (state)
            S_IDLE: begin
                if (push)     state_nxt = full  ? S_FAULT : S_PUSH_DEC;
                else if (pop) state_nxt = empty ? S_FAULT : S_POP_ADDR;
            end
            S_PUSH_DEC: begin
                strb.sp_cdownn = 1'b0;
                state_nxt      = S_PUSH_ADDR;
            end
            S_PUSH_ADDR: begin
                strb.sp_outn   = 1'b0;
                strb.mar_loadn = 1'b0;
                state_nxt      = S_PUSH_WR;
            end
            S_PUSH_WR: begin
                strb.mem_wen = 1'b0;
                state_nxt    = S_DONE;
            end
            S_POP_ADDR: begin
                strb.sp_outn   = 1'b0;
                strb.mar_loadn = 1'b0;
                state_nxt      = S_POP_RD;
            end
            S_POP_RD: begin
                strb.mem_oen = 1'b0;
                state_nxt    = S_POP_INC;
            end
            S_POP_INC: begin
                strb.sp_cupn = 1'b0;
                state_nxt    = S_DONE;
            end
            S_FAULT: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Push wins when both requests arrive together; the pop is simply dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wdata <= '0;
            dout      <= '0;
            err       <= 1'b0;
            depth     <= '0;
            op        <= OP_FAULT;
        end else begin
            if (state == S_IDLE) begin
                if (push) begin
                    if (full) begin
                        err <= 1'b1;
                        op  <= OP_FAULT;
                    end else begin
                        err       <= 1'b0;
                        op        <= OP_PUSH;
                        mem_wdata <= din;
                    end
                end else if (pop) begin
                    if (empty) begin
                        err <= 1'b1;
                        op  <= OP_FAULT;
                    end else begin
                        err <= 1'b0;
                        op  <= OP_POP;
                    end
                end
            end
            if (state == S_POP_RD) dout <= mem_rdata;
            if (state == S_DONE) begin
                if (op == OP_PUSH && !full)      depth <= depth + 1'b1;
                else if (op == OP_POP && !empty) depth <= depth - 1'b1;
            end
        end
    end

    assign sp_cdownn = strb.sp_cdownn;
    assign sp_cupn   = strb.sp_cupn;
    assign sp_outn   = strb.sp_outn;
    assign mar_loadn = strb.mar_loadn;
    assign mem_wen   = strb.mem_wen;
    assign mem_oen   = strb.mem_oen;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule
